// File: rtl/imem_if.sv
// -----------------------------------------------------------------------------
// imem_if
// Instruction-memory fetch handshake between the fetch stage and the
// instruction memory.
//   imem_req    : fetch request, held high until imem_rvalid
//   imem_addr   : fetch address (word aligned PC)
//   imem_rvalid : instruction data valid, may arrive in the request cycle
//   imem_rdata  : instruction word, meaningful when imem_req && imem_rvalid
// Modports:
//   master : the fetch unit (drives request/address)
//   slave  : the instruction memory (drives valid/data)
// -----------------------------------------------------------------------------
interface imem_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
// Instruction-fetch stage of the single-cycle MIPS core. Owns the PC, fetches
// one instruction per REQ phase over the imem handshake, presents it to the
// decoder for exactly one EXEC cycle, then updates the PC from Branch/Jump/zero.
//
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   imem         : imem_if.master fetch handshake (req/addr out, rvalid/rdata in)
//   instr, op    : latched instruction register and its opcode field
//   instr_valid  : high only in the EXEC cycle; qualifies downstream writes
//   pc, pc_plus4 : current instruction address and its sequential successor
//   Branch, Jump : control decoder outputs, consumed only in EXEC
//   zero         : ALU zero flag, consumed only in EXEC
//   retired      : count of completed EXEC cycles, wraps to 0
// -----------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_if.master           imem,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             zero,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] branch_off;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic        req_w;
  logic        valid_w;

  // All PC arithmetic is 32-bit; the carry out of bit 31 simply falls off.
  assign pc_plus4_w  = pc_q + 32'd4;
  assign branch_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jump_target = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};

  // Jump wins over a taken branch even though the decoder never asserts both.
  always_comb begin
    next_pc = pc_plus4_w;
    if (Jump) begin
      next_pc = jump_target;
    end else if (Branch && zero) begin
      next_pc = pc_plus4_w + branch_off;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    req_w     = 1'b0;
    valid_w   = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        req_w = 1'b1;
        if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        valid_w   = 1'b1;
        pc_d      = next_pc;
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d   = S_REQ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0000_0000;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // imem_req is decoded from the state register, so an asynchronous reset
  // drops it immediately and the address (pc_q) stays stable through a stall.
  assign imem.imem_req  = req_w;
  assign imem.imem_addr = pc_q;

  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign instr_valid = valid_w;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign retired     = retired_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
// Drives ifetch_unit with an instruction-memory/decoder model: directed
// fetches covering sequential flow, stalls, branches, jumps and PC wrap,
// followed by randomized fetches and a reset in the middle of a request.
// Expected EXEC presentations are queued as each instruction is handed over
// and checked by an independent monitor.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] ORI_W    = 32'h3408_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Branch = 1'b0;
  logic        Jump = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] retired;

  imem_if imem ();

  ifetch_unit #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem),
    .instr      (instr),
    .op         (op),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .Branch     (Branch),
    .Jump       (Jump),
    .zero       (zero),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retired;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_retired = 32'd0;
  logic [31:0] last_word = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next-PC computed from the architectural rules with plain
  // arithmetic on the model's own PC and instruction word.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] w,
                                             input logic br, input logic jp, input logic z);
    logic [31:0]        seq;
    logic signed [15:0] imm;
    int                 off;
    seq = cur_pc + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (br && z) begin
      imm = w[15:0];
      off = int'(imm) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  task automatic junk_ctrl();
    Branch = 1'($urandom_range(0, 1));
    Jump   = 1'($urandom_range(0, 1));
    zero   = 1'($urandom_range(0, 1));
  endtask

  // Serve one fetch: wait for the request, stall `waits` cycles, hand over
  // word `w`, then drive the decoder outputs during EXEC. Returns at the
  // falling edge of the cycle following EXEC.
  task automatic fetch_one(input logic [31:0] w, input int waits,
                           input logic br, input logic jp, input logic z);
    int cnt;
    cnt = 0;
    while (imem.imem_req !== 1'b1 && cnt < 20) begin
      imem.imem_rvalid = 1'($urandom_range(0, 1));
      imem.imem_rdata  = $urandom;
      junk_ctrl();
      @(negedge clk);
      cnt++;
    end
    check("req_seen", {31'b0, imem.imem_req}, 32'd1);
    if (imem.imem_req !== 1'b1) return;
    check("req_addr", imem.imem_addr, m_pc);
    check("retired_at_req", retired, m_retired);
    for (int i = 0; i < waits; i++) begin
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = $urandom;
      junk_ctrl();
      @(negedge clk);
      check("stall_req_held", {31'b0, imem.imem_req}, 32'd1);
      check("stall_addr_held", imem.imem_addr, m_pc);
      check("stall_no_valid", {31'b0, instr_valid}, 32'd0);
      check("stall_instr_kept", instr, last_word);
    end
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = w;
    junk_ctrl();
    sb.push_back('{pc: m_pc, instr: w, retired: m_retired});
    @(negedge clk);
    // EXEC: memory chatter must be ignored, decoder outputs are consumed.
    imem.imem_rvalid = 1'($urandom_range(0, 1));
    imem.imem_rdata  = $urandom;
    Branch = br;
    Jump   = jp;
    zero   = z;
    m_pc      = model_next(m_pc, w, br, jp, z);
    m_retired = m_retired + 32'd1;
    last_word = w;
    @(negedge clk);
    imem.imem_rvalid = 1'b0;
  endtask

  // Monitor: every EXEC presentation is compared against the oldest queued
  // expectation.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid) begin
        check("valid_not_back_to_back", {31'b0, prev_v}, 32'd0);
        check("exec_expected", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("exec_pc", pc, e.pc);
          check("exec_pc_plus4", pc_plus4, e.pc + 32'd4);
          check("exec_instr", instr, e.instr);
          check("exec_op", {26'b0, op}, {26'b0, e.instr[31:26]});
          check("exec_retired", retired, e.retired);
          check("exec_no_req", {31'b0, imem.imem_req}, 32'd0);
        end
      end
      prev_v = rst_n && instr_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, imem.imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc", pc, RESET_PC);
    check("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
    check("rst_instr", instr, 32'd0);
    check("rst_op", {26'b0, op}, 32'd0);
    check("rst_retired", retired, 32'd0);

    // Release: one IDLE cycle, then the request to RESET_PC
    rst_n = 1'b1;
    #1;
    check("idle_no_req", {31'b0, imem.imem_req}, 32'd0);
    @(negedge clk);
    check("first_req", {31'b0, imem.imem_req}, 32'd1);
    check("first_addr", imem.imem_addr, RESET_PC);

    // Sequential zero-wait ori fetches
    fetch_one(ORI_W, 0, 1'b0, 1'b0, 1'b0);
    fetch_one(ORI_W, 0, 1'b0, 1'b0, 1'b0);
    fetch_one(ORI_W, 0, 1'b0, 1'b0, 1'b0);
    // Stalled beq (3 wait cycles), taken back to 0x3008
    fetch_one(32'h1000_FFFE, 3, 1'b1, 1'b0, 1'b1);
    // beq taken at 0x3008 -> 0x3004, then not taken at 0x3004 -> 0x3008
    fetch_one(32'h1000_FFFE, 0, 1'b1, 1'b0, 1'b1);
    fetch_one(32'h1000_FFFE, 1, 1'b1, 1'b0, 1'b0);
    // Jump with Branch also asserted, then a plain jump
    fetch_one(32'h0800_0C00, 0, 1'b1, 1'b1, 1'b1);
    fetch_one(32'h0800_0C00, 2, 1'b0, 1'b1, 1'b0);
    // Taken branch to 0xFFFFFFFC, then sequential wrap to 0
    fetch_one(32'h1000_F3FE, 0, 1'b1, 1'b0, 1'b1);
    fetch_one(ORI_W, 0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 200; k++) begin
      fetch_one($urandom, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a stalled request
    cnt = 0;
    while (imem.imem_req !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("pre_reset_req", {31'b0, imem.imem_req}, 32'd1);
    imem.imem_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_drop", {31'b0, imem.imem_req}, 32'd0);
    check("mid_rst_pc", pc, RESET_PC);
    check("mid_rst_retired", retired, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", {31'b0, imem.imem_req}, 32'd0);
    @(negedge clk);
    imem.imem_rvalid = 1'b0;
    check("late_rvalid_ignored", instr, 32'd0);
    m_pc      = RESET_PC;
    m_retired = 32'd0;
    last_word = 32'd0;
    fetch_one(ORI_W, 1, 1'b0, 1'b0, 1'b0);
    fetch_one(ORI_W, 0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
